// File: rtl/guarded_release_pkg.sv
// guarded_release_pkg
//   Shared constants and helpers for the guarded release receiver.
//   - Default data/phase widths, FIFO depth.
//   - Release and reset phase values, matching the sender's trailing counter.
//   - phase_t and phase_inc(): wrap-around increment of the phase counter.
package guarded_release_pkg;

   localparam int DATA_W_DEF    = 32;
   localparam int PHASE_W_DEF   = 2;
   localparam int REL_PHASE_DEF = 1;
   localparam int RST_PHASE_DEF = 3;
   localparam int DEPTH_DEF     = 4;

   typedef logic [PHASE_W_DEF-1:0] phase_t;

   // Increment relies on natural truncation to wrap modulo 2^PHASE_W.
   function automatic phase_t phase_inc(input phase_t p);
      return p + phase_t'(1);
   endfunction

endpackage

// File: rtl/guarded_release_rx_fifo.sv
// release_fifo
//   DEPTH x DATA_W synchronous FIFO holding accepted released words.
//   Ports:
//     clk, rst_n      clock, async active-low reset (empties the FIFO)
//     push, din       write request and data; accepted when not full, or
//                     when full and a pop happens on the same edge
//     pop             remove head; ignored when empty
//     dout            head word, combinational, forced to 0 when empty
//     count           occupancy 0..DEPTH
//     full, empty     status
module release_fifo
   import guarded_release_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic [CW-1:0]     count,
   output logic              full,
   output logic              empty
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              w_do_pop;
   logic              w_do_push;

   assign empty     = (r_count == '0);
   assign full      = (r_count == CW'(DEPTH));
   assign w_do_pop  = pop & ~empty;
   // A full FIFO still takes a word when the head leaves on the same edge.
   assign w_do_push = push & (~full | w_do_pop);

   // Pointers are AW bits wide and DEPTH is a power of two, so they wrap by truncation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage is not reset; stale words are hidden by the zero-on-empty head.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= din;
   end

   assign dout  = empty ? '0 : r_mem[r_rd_ptr];
   assign count = r_count;

endmodule

// File: rtl/guarded_release_rx.sv
// guarded_release_rx
//   Receiver of a phase-gated secret-release channel. Mirrors the sender's
//   trailing phase counter, accepts non-zero bus words only in the release
//   window, buffers them in a FIFO and flags out-of-window data as a leak.
//   Ports:
//     clk, rst_n           clock, async active-low reset
//     enable, sync         phase advance / reload to RST_PHASE (sync wins)
//     din                  released-data bus
//     clear_err            clears leak_err and overflow (a new error wins)
//     out_valid/out_ready  output handshake, out_data is the FIFO head
//     count                FIFO occupancy
//     phase                mirrored phase
//     leak_err, overflow   sticky error flags
module guarded_release_rx
   import guarded_release_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int PHASE_W   = PHASE_W_DEF,
   parameter int REL_PHASE = REL_PHASE_DEF,
   parameter int RST_PHASE = RST_PHASE_DEF,
   parameter int DEPTH     = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic                     sync,
   input  logic [DATA_W-1:0]        din,
   input  logic                     clear_err,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic [PHASE_W-1:0]       phase,
   output logic                     leak_err,
   output logic                     overflow
);

   logic [PHASE_W-1:0] r_phase;
   logic [PHASE_W-1:0] w_phase_inc;
   logic               r_leak_err;
   logic               r_overflow;
   logic               w_in_win;
   logic               w_nonzero;
   logic               w_push_req;
   logic               w_leak;
   logic               w_pop;
   logic               w_full;
   logic               w_empty;
   logic               w_drop;

   generate
      if (PHASE_W == PHASE_W_DEF) begin : g_pkg_inc
         assign w_phase_inc = phase_inc(r_phase);
      end else begin : g_wide_inc
         assign w_phase_inc = r_phase + PHASE_W'(1);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_phase <= PHASE_W'(RST_PHASE);
      else if (sync)   r_phase <= PHASE_W'(RST_PHASE);
      else if (enable) r_phase <= w_phase_inc;
   end

   // Window uses the phase held before this edge's update.
   assign w_in_win   = (r_phase == PHASE_W'(REL_PHASE));
   assign w_nonzero  = |din;
   assign w_push_req = w_in_win & w_nonzero;
   assign w_leak     = ~w_in_win & w_nonzero;
   assign w_pop      = out_valid & out_ready;
   assign w_drop     = w_push_req & w_full & ~w_pop;

   // Set has priority over clear so an error in the clearing cycle is kept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_leak_err <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_leak)         r_leak_err <= 1'b1;
         else if (clear_err) r_leak_err <= 1'b0;
         if (w_drop)         r_overflow <= 1'b1;
         else if (clear_err) r_overflow <= 1'b0;
      end
   end

   release_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push_req),
      .din   (din),
      .pop   (w_pop),
      .dout  (out_data),
      .count (count),
      .full  (w_full),
      .empty (w_empty)
   );

   assign out_valid = ~w_empty;
   assign phase     = r_phase;
   assign leak_err  = r_leak_err;
   assign overflow  = r_overflow;

endmodule
